// File: rtl/alu_serdes_pkg.sv
// Shared types and helpers for the bit-serial ALU front/back end.
package alu_serdes_pkg;

  // Sequencer-side state of the serial transfer engine.
  typedef enum logic [1:0] {
    SERDES_IDLE = 2'd0,
    SERDES_RUN  = 2'd1,
    SERDES_RESP = 2'd2
  } serdes_state_e;

  // The chunk counter must be able to hold the full chunk count itself,
  // so it needs one bit more than the index width.
  function automatic int serdes_cnt_bits(input int n_chunks);
    return $clog2(n_chunks) + 1;
  endfunction

endpackage

// File: rtl/alu_serdes_shift_reg.sv
// Multi-bit serial shift register: parallel load, NSHIFT bits enter at the
// MSB end and leave from the LSB end on each enabled cycle.
module serial_shift_reg #(
  parameter int WIDTH  = 16,
  parameter int NSHIFT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_val,
  input  logic              i_shift,
  input  logic [NSHIFT-1:0] i_sin,
  output logic [WIDTH-1:0]  o_q,
  output logic [NSHIFT-1:0] o_sout
);

  logic [WIDTH-1:0] r_q;

  // Load has priority over shift; shifting pulls i_sin in at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= {i_sin, r_q[WIDTH-1:NSHIFT]};
    end
  end

  assign o_q    = r_q;
  assign o_sout = r_q[NSHIFT-1:0];

endmodule

// File: rtl/alu_serdes.sv
// Parallel-to-serial operand feeder and serial-to-parallel result collector
// sitting in front of the bit-serial ALU.
module alu_serdes
  import alu_serdes_pkg::*;
#(
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_pair,
  input  logic                  req_capture,
  input  logic [2*REG_BITS-1:0] req_operand1,
  input  logic [2*REG_BITS-1:0] req_operand2,
  output logic                  alu_op_valid,
  input  logic                  alu_op_done,
  input  logic                  alu_active,
  output logic [NSHIFT-1:0]     alu_data_in1,
  output logic [NSHIFT-1:0]     alu_data_in2,
  input  logic [NSHIFT-1:0]     alu_data_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*REG_BITS-1:0] rsp_data,
  output logic                  busy
);

  localparam int WORD_W   = 2 * REG_BITS;
  localparam int N_CHUNKS = WORD_W / NSHIFT;
  localparam int CNT_W    = serdes_cnt_bits(N_CHUNKS);
  localparam int SH_W     = $clog2(WORD_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_CHUNKS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(N_CHUNKS / 2);

  serdes_state_e    r_state;
  serdes_state_e    w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pair;
  logic             r_capture;
  logic             w_load;
  logic             w_shift;
  logic             w_done_fire;
  logic [CNT_W-1:0] w_gap;
  logic [SH_W-1:0]  w_shamt;
  logic [WORD_W-1:0] w_res_q;
  logic [WORD_W-1:0] w_op1_q_unused;
  logic [WORD_W-1:0] w_op2_q_unused;
  logic [NSHIFT-1:0] w_res_sout_unused;

  // Operand 1: parallel load on accept, streamed out LSB first.
  serial_shift_reg #(.WIDTH(WORD_W), .NSHIFT(NSHIFT)) u_op1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (req_operand1),
    .i_shift    (w_shift),
    .i_sin      ({NSHIFT{1'b0}}),
    .o_q        (w_op1_q_unused),
    .o_sout     (alu_data_in1)
  );

  // Operand 2: same shape as operand 1.
  serial_shift_reg #(.WIDTH(WORD_W), .NSHIFT(NSHIFT)) u_op2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (req_operand2),
    .i_shift    (w_shift),
    .i_sin      ({NSHIFT{1'b0}}),
    .o_q        (w_op2_q_unused),
    .o_sout     (alu_data_in2)
  );

  // Result: cleared on accept, ALU output enters at the MSB end.
  serial_shift_reg #(.WIDTH(WORD_W), .NSHIFT(NSHIFT)) u_res (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val ({WORD_W{1'b0}}),
    .i_shift    (w_shift),
    .i_sin      (alu_data_out),
    .o_q        (w_res_q),
    .o_sout     (w_res_sout_unused)
  );

  // State register; reset drops straight to IDLE, discarding any partial op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SERDES_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Chunk counter (saturating) and request flags latched at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_pair    <= 1'b0;
      r_capture <= 1'b0;
    end else if (w_load) begin
      r_cnt     <= '0;
      r_pair    <= req_pair;
      r_capture <= req_capture;
    end else if (w_shift && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Next-state and handshake outputs, decoded from the registered state.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    alu_op_valid = 1'b0;
    rsp_valid    = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    unique case (r_state)
      SERDES_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_load       = 1'b1;
          w_state_next = SERDES_RUN;
        end
      end
      SERDES_RUN: begin
        alu_op_valid = 1'b1;
        if (alu_active) begin
          w_shift = 1'b1;
          if (alu_op_done) begin
            w_state_next = r_capture ? SERDES_RESP : SERDES_IDLE;
          end
        end
      end
      SERDES_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = SERDES_IDLE;
        end
      end
      default: begin
        w_state_next = SERDES_IDLE;
      end
    endcase
  end

  assign w_done_fire = (r_state == SERDES_RUN) && alu_active && alu_op_done;
  assign busy        = (r_state != SERDES_IDLE);

  // Collected chunks sit at the top of the result register; slide them down
  // so a short transfer comes out right-aligned.
  assign w_gap    = CNT_MAX - r_cnt;
  assign w_shamt  = SH_W'(int'(w_gap) * NSHIFT);
  assign rsp_data = w_res_q >> w_shamt;

  // An 8-bit operation should never stream more than one register's worth.
  a_narrow_len: assert property (@(posedge clk) disable iff (!rst_n)
    w_done_fire |-> (r_pair || (r_cnt < CNT_HALF)));

endmodule

// File: tb/tb_alu_serdes.sv
// Directed bench for alu_serdes: echo-style ALU model, hand-computed vectors.
module tb_alu_serdes;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_pair;
  logic        req_capture;
  logic [15:0] req_operand1;
  logic [15:0] req_operand2;
  logic        alu_op_valid;
  logic        alu_op_done;
  logic        alu_active;
  logic [1:0]  alu_data_in1;
  logic [1:0]  alu_data_in2;
  logic [1:0]  alu_data_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        busy;

  logic        echo;
  logic [1:0]  dout_drv;
  int          n_checks;
  int          n_err;

  // The ALU model either echoes data_in1 or plays a fixed value.
  assign alu_data_out = echo ? alu_data_in1 : dout_drv;

  alu_serdes #(.REG_BITS(8), .NSHIFT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_pair     (req_pair),
    .req_capture  (req_capture),
    .req_operand1 (req_operand1),
    .req_operand2 (req_operand2),
    .alu_op_valid (alu_op_valid),
    .alu_op_done  (alu_op_done),
    .alu_active   (alu_active),
    .alu_data_in1 (alu_data_in1),
    .alu_data_in2 (alu_data_in2),
    .alu_data_out (alu_data_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic pair, input logic cap, input logic [15:0] op1, input logic [15:0] op2);
    req_valid    = 1'b1;
    req_pair     = pair;
    req_capture  = cap;
    req_operand1 = op1;
    req_operand2 = op2;
    tick();
    req_valid    = 1'b0;
    req_operand1 = 16'hFFFF;
    req_operand2 = 16'hFFFF;
    $display("request pair=%0b capture=%0b op1=%h op2=%h accepted", pair, cap, op1, op2);
  endtask

  logic [1:0] exp16 [8];
  logic [1:0] exp8  [4];

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_pair = 1'b0; req_capture = 1'b0;
    req_operand1 = '0; req_operand2 = '0; alu_op_done = 1'b0; alu_active = 1'b0;
    rsp_ready = 1'b0; echo = 1'b0; dout_drv = 2'd0;
    exp16 = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
    exp8  = '{2'd1, 2'd1, 2'd2, 2'd2};

    // Reset state
    #2;
    check("rst_req_ready", req_ready, 1);
    check("rst_op_valid", alu_op_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_din1", alu_data_in1, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // 16-bit operation, echo model
    echo = 1'b1; alu_active = 1'b1;
    request(1'b1, 1'b1, 16'h1234, 16'h5679);
    check("t16_din2_first", alu_data_in2, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t16_din1_%0d", i), alu_data_in1, exp16[i]);
      check($sformatf("t16_opv_%0d", i), alu_op_valid, 1);
      check($sformatf("t16_rspv_early_%0d", i), rsp_valid, 0);
      alu_op_done = (i == 7);
      tick();
    end
    alu_op_done = 1'b0;
    check("t16_rsp_valid", rsp_valid, 1);
    check("t16_rsp_data", rsp_data, 16'h1234);
    check("t16_opv_drop", alu_op_valid, 0);
    $display("op 16-bit rsp_data=%h", rsp_data);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t16_idle", busy, 0);

    // 8-bit operation
    request(1'b0, 1'b1, 16'h00A5, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t8_din1_%0d", i), alu_data_in1, exp8[i]);
      alu_op_done = (i == 3);
      tick();
    end
    alu_op_done = 1'b0;
    check("t8_rsp_valid", rsp_valid, 1);
    check("t8_rsp_data", rsp_data, 16'h00A5);
    check("t8_opv_after_done", alu_op_valid, 0);
    $display("op 8-bit rsp_data=%h", rsp_data);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Rotate-length operation with fixed ALU output, then backpressure
    echo = 1'b0; dout_drv = 2'd3;
    request(1'b0, 1'b1, 16'h0F0F, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      alu_op_done = (i == 2);
      tick();
    end
    alu_op_done = 1'b0;
    check("rot_rsp_valid", rsp_valid, 1);
    check("rot_rsp_data", rsp_data, 16'h003F);
    check("rot_cnt", dut.r_cnt, 3);
    $display("op rotate rsp_data=%h", rsp_data);
    req_valid = 1'b1; req_operand1 = 16'hAAAA;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_rsp_valid_%0d", i), rsp_valid, 1);
      check($sformatf("bp_rsp_data_%0d", i), rsp_data, 16'h003F);
      check($sformatf("bp_req_ready_%0d", i), req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    check("bp_req_ready_hs", req_ready, 0);
    tick();
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("bp_req_ready_after", req_ready, 1);
    check("bp_rsp_valid_after", rsp_valid, 0);
    check("bp_busy_after", busy, 0);
    $display("backpressure handshake complete");

    // Stall cycles and no-capture operation
    echo = 1'b1;
    request(1'b1, 1'b0, 16'h00E4, 16'h0000);
    check("st_din1_0", alu_data_in1, 0);
    tick();
    check("st_din1_1", alu_data_in1, 1);
    tick();
    alu_active = 1'b0; alu_op_done = 1'b1;
    check("st_din1_2", alu_data_in1, 2);
    tick();
    alu_op_done = 1'b0;
    check("st_hold_din1", alu_data_in1, 2);
    check("st_hold_busy", busy, 1);
    check("st_hold_opv", alu_op_valid, 1);
    check("st_hold_cnt", dut.r_cnt, 2);
    tick();
    check("st_hold2_din1", alu_data_in1, 2);
    check("st_hold2_cnt", dut.r_cnt, 2);
    check("st_hold2_rspv", rsp_valid, 0);
    alu_active = 1'b1; alu_op_done = 1'b1;
    tick();
    alu_op_done = 1'b0;
    check("st_end_busy", busy, 0);
    check("st_end_rspv", rsp_valid, 0);
    check("st_end_opv", alu_op_valid, 0);
    check("st_end_cnt", dut.r_cnt, 3);
    $display("stall/no-capture op complete");

    // Reset in the middle of RUN
    request(1'b1, 1'b1, 16'h1111, 16'h0000);
    tick();
    check("rr_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_opv", alu_op_valid, 0);
    check("rr_busy", busy, 0);
    check("rr_rspv", rsp_valid, 0);
    check("rr_din1", alu_data_in1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    request(1'b1, 1'b1, 16'hBEEF, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      alu_op_done = (i == 7);
      tick();
    end
    alu_op_done = 1'b0;
    check("rr_rsp_valid", rsp_valid, 1);
    check("rr_rsp_data", rsp_data, 16'hBEEF);
    $display("op after reset rsp_data=%h", rsp_data);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rr_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
